// File: rtl/npu_pkg.sv
// Shared types and constants for the NPU engine and its address generation unit.
package npu_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    MAC  = 3'd3,
    WR   = 3'd4,
    DONE = 3'd5
  } npu_state_t;

  typedef enum logic {
    OP_MATMUL = 1'b0,
    OP_CONV   = 1'b1
  } npu_op_t;

  localparam int unsigned NPU_ELEM_BYTES = 8;

  // Byte address of element idx in a row-major array starting at base.
  function automatic logic [63:0] elem_addr(input logic [63:0] base, input logic [63:0] idx);
    return base + idx * 64'(NPU_ELEM_BYTES);
  endfunction

endpackage

// File: rtl/npu_agu.sv
// Address generation unit: i/j/k loop counters, latched base addresses and
// operation, element addresses for the A/x, B/h and C/y streams, and the
// end-of-dot-product / end-of-operation flags.
// Optional feature macro: NPU_CONV_EN (convolution address mode and LEN bound).
module npu_agu
  import npu_pkg::*;
#(
  parameter int N   = 4,
  parameter int LEN = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
`ifdef NPU_CONV_EN
  input  logic        op_i,
`endif
  input  logic [63:0] a_base_i,
  input  logic [63:0] b_base_i,
  input  logic [63:0] c_base_i,
  input  logic        step_k_i,
  input  logic        step_elem_i,
  output logic [63:0] addr_a_o,
  output logic [63:0] addr_b_o,
  output logic [63:0] addr_c_o,
  output logic        last_k_o,
  output logic        last_elem_o
);

  // Wide enough for the largest matrix index and the convolution output count.
  localparam int CW = $clog2(LEN + N * N + 1) + 1;
  localparam logic [CW-1:0] ONE = 1;

  logic [CW-1:0] i_q, j_q, k_q;
  logic [63:0]   a_base_q, b_base_q, c_base_q;
`ifdef NPU_CONV_EN
  npu_op_t       op_q;
`endif
  logic [63:0]   i64, j64, k64, idx_a, idx_b, idx_c;

  // Loop counters and latched command: load on start, k steps after each MAC,
  // the element counters step after each write-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      a_base_q <= '0;
      b_base_q <= '0;
      c_base_q <= '0;
`ifdef NPU_CONV_EN
      op_q     <= OP_MATMUL;
`endif
    end else if (load_i) begin
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      a_base_q <= a_base_i;
      b_base_q <= b_base_i;
      c_base_q <= c_base_i;
`ifdef NPU_CONV_EN
      op_q     <= npu_op_t'(op_i);
`endif
    end else if (step_elem_i) begin
      k_q <= '0;
`ifdef NPU_CONV_EN
      if (op_q == OP_CONV) i_q <= i_q + ONE;
      else
`endif
      if (j_q == CW'(N - 1)) begin
        j_q <= '0;
        i_q <= i_q + ONE;
      end else begin
        j_q <= j_q + ONE;
      end
    end else if (step_k_i) begin
      k_q <= k_q + ONE;
    end
  end

  // Element indices and flags for the current operation mode.
  always_comb begin
    i64         = 64'(i_q);
    j64         = 64'(j_q);
    k64         = 64'(k_q);
    idx_a       = i64 * 64'(N) + k64;
    idx_b       = k64 * 64'(N) + j64;
    idx_c       = i64 * 64'(N) + j64;
    last_elem_o = (i_q == CW'(N - 1)) && (j_q == CW'(N - 1));
`ifdef NPU_CONV_EN
    if (op_q == OP_CONV) begin
      idx_a       = i64 + k64;
      idx_b       = k64;
      idx_c       = i64;
      last_elem_o = (i_q == CW'(LEN - N));
    end
`endif
  end

  assign last_k_o = (k_q == CW'(N - 1));
  assign addr_a_o = elem_addr(a_base_q, idx_a);
  assign addr_b_o = elem_addr(b_base_q, idx_b);
  assign addr_c_o = elem_addr(c_base_q, idx_c);

endmodule

// File: rtl/npu_engine.sv
// NPU engine: command FSM, single-outstanding memory port and the 64-bit
// wrapping multiply-accumulate datapath. Addressing lives in npu_agu.
// Optional feature macro: NPU_CONV_EN (1-D valid convolution command).
module npu_engine
  import npu_pkg::*;
#(
  parameter int N   = 4,
  parameter int LEN = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        npu_start_matrix_mul,
  input  logic        npu_start_conv,
  input  logic [63:0] cfg_a_addr,
  input  logic [63:0] cfg_b_addr,
  input  logic [63:0] cfg_c_addr,
  output logic        npu_done,
  output logic        npu_busy,
  output logic        npu_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  input  logic        mem_ack
);

  npu_state_t  state_q, state_d;
  logic [63:0] acc_q, acc_d;
  logic [63:0] a_q, b_q;
  logic        err_q, err_d;
  logic        load, step_k, step_elem;
  logic        last_k, last_elem;
  logic [63:0] addr_a, addr_b, addr_c;
`ifdef NPU_CONV_EN
  npu_op_t     op_d;
`endif

  // Products keep the low 64 bits and the sum wraps modulo 2^64.
  function automatic logic [63:0] mac_wrap(input logic [63:0] acc, input logic [63:0] a,
                                           input logic [63:0] b);
    return acc + a * b;
  endfunction

  npu_agu #(.N(N), .LEN(LEN)) u_agu (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (load),
`ifdef NPU_CONV_EN
    .op_i        (op_d),
`endif
    .a_base_i    (cfg_a_addr),
    .b_base_i    (cfg_b_addr),
    .c_base_i    (cfg_c_addr),
    .step_k_i    (step_k),
    .step_elem_i (step_elem),
    .addr_a_o    (addr_a),
    .addr_b_o    (addr_b),
    .addr_c_o    (addr_c),
    .last_k_o    (last_k),
    .last_elem_o (last_elem)
  );

  // State, accumulator and reject flag; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
    end
  end

  // Operand capture in the ack cycle of each read.
  always_ff @(posedge clk) begin
    if (state_q == RD_A && mem_ack) a_q <= mem_rdata;
    if (state_q == RD_B && mem_ack) b_q <= mem_rdata;
  end

  // Next-state logic: start decode, memory handshakes, MAC loop control.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    err_d     = err_q;
    load      = 1'b0;
    step_k    = 1'b0;
    step_elem = 1'b0;
`ifdef NPU_CONV_EN
    op_d      = OP_MATMUL;
`endif
    case (state_q)
      IDLE: begin
        err_d = 1'b0;
        if (npu_start_matrix_mul && npu_start_conv) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else if (npu_start_matrix_mul) begin
          load    = 1'b1;
          acc_d   = '0;
          state_d = RD_A;
        end else if (npu_start_conv) begin
`ifdef NPU_CONV_EN
          load    = 1'b1;
          op_d    = OP_CONV;
          acc_d   = '0;
          state_d = RD_A;
`else
          state_d = DONE;
          err_d   = 1'b1;
`endif
        end
      end
      RD_A: if (mem_ack) state_d = RD_B;
      RD_B: if (mem_ack) state_d = MAC;
      MAC: begin
        acc_d = mac_wrap(acc_q, a_q, b_q);
        if (last_k) begin
          state_d = WR;
        end else begin
          step_k  = 1'b1;
          state_d = RD_A;
        end
      end
      WR: begin
        if (mem_ack) begin
          step_elem = 1'b1;
          acc_d     = '0;
          state_d   = last_elem ? DONE : RD_A;
        end
      end
      DONE: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; address/data held constant while waiting on ack.
  always_comb begin
    mem_req   = (state_q == RD_A) || (state_q == RD_B) || (state_q == WR);
    mem_we    = (state_q == WR);
    mem_wdata = (state_q == WR) ? acc_q : 64'd0;
    case (state_q)
      RD_A:    mem_addr = addr_a;
      RD_B:    mem_addr = addr_b;
      WR:      mem_addr = addr_c;
      default: mem_addr = 64'd0;
    endcase
    npu_done = (state_q == DONE);
    npu_err  = (state_q == DONE) && err_q;
    npu_busy = (state_q != IDLE);
  end

endmodule

// File: tb/tb_npu_engine.sv
// Self-checking bench for npu_engine: vector table of commands and memory
// patterns, a memory responder with random ack latency, and a loop-level
// reference model of the matrix product and the valid convolution.
module tb_npu_engine;

  localparam int N    = 4;
  localparam int LEN  = 16;
  localparam int MAXE = (N * N > LEN) ? N * N : LEN;
  localparam logic [63:0] A_BASE = 64'h1000;
  localparam logic [63:0] B_BASE = 64'h2000;
  localparam logic [63:0] C_BASE = 64'h3000;
  localparam int A_W = 512, B_W = 1024, C_W = 1536;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        smm = 1'b0, scv = 1'b0;
  logic [63:0] cfg_a = A_BASE, cfg_b = B_BASE, cfg_c = C_BASE;
  logic        npu_done, npu_busy, npu_err;
  logic        mem_req, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic [63:0] mem_rdata = 64'd0;
  logic        mem_ack = 1'b0;

  always #5 clk = ~clk;

  npu_engine #(.N(N), .LEN(LEN)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .npu_start_matrix_mul (smm),
    .npu_start_conv       (scv),
    .cfg_a_addr           (cfg_a),
    .cfg_b_addr           (cfg_b),
    .cfg_c_addr           (cfg_c),
    .npu_done             (npu_done),
    .npu_busy             (npu_busy),
    .npu_err              (npu_err),
    .mem_req              (mem_req),
    .mem_we               (mem_we),
    .mem_addr             (mem_addr),
    .mem_wdata            (mem_wdata),
    .mem_rdata            (mem_rdata),
    .mem_ack              (mem_ack)
  );

  int n_pass = 0, n_tot = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  // ---------------- memory responder ----------------
  logic [63:0] mem [0:2047];
  int          wcnt = 0, maxw = 0, waits = 0, n_wr = 0, rd_since_wr = 0;
  int          bad_order = 0, bad_stable = 0, req_seen = 0;
  bit          prev_wait = 0;
  logic [63:0] p_addr = 0, p_wd = 0;
  logic        p_we = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      mem_ack   = 1'b0;
      prev_wait = 0;
    end else begin
      if (prev_wait && !(mem_req && mem_addr == p_addr && mem_we == p_we && mem_wdata == p_wd))
        bad_stable++;
      prev_wait = 0;
      if (mem_req) begin
        req_seen++;
        if (wcnt == 0) begin
          mem_ack = 1'b1;
          if (mem_we) begin
            mem[int'(mem_addr[13:3])] = mem_wdata;
            n_wr++;
            if (rd_since_wr != 2 * N) bad_order++;
            rd_since_wr = 0;
          end else begin
            mem_rdata = mem[int'(mem_addr[13:3])];
            rd_since_wr++;
          end
          wcnt = $urandom_range(0, maxw);
        end else begin
          mem_ack   = 1'b0;
          wcnt--;
          waits++;
          prev_wait = 1;
          p_addr    = mem_addr;
          p_we      = mem_we;
          p_wd      = mem_wdata;
        end
      end else begin
        mem_ack = 1'b0;
      end
    end
  end

  // ---------------- stimulus and reference model ----------------
  typedef struct {
    bit          mm;
    bit          cv;
    int          pat;
    int          maxw;
    bit          noise;
    bit          exp_err;
    int          exp_cyc;
    bit          chk_ends;
    logic [63:0] exp_first;
    logic [63:0] exp_last;
  } vec_t;

  logic [63:0] exp_c [0:63];

  function automatic vec_t mk(bit mm, bit cv, int pat, int mw, bit noise, bit err, int cyc,
                              bit ce, logic [63:0] f, logic [63:0] l);
    vec_t v;
    v.mm = mm; v.cv = cv; v.pat = pat; v.maxw = mw; v.noise = noise; v.exp_err = err;
    v.exp_cyc = cyc; v.chk_ends = ce; v.exp_first = f; v.exp_last = l;
    return v;
  endfunction

  task automatic fill(input int pat);
    logic [63:0] a, b;
    for (int w = 0; w < 2048; w++) mem[w] = 64'hA5A5_0000_0000_0000 | 64'(w);
    for (int m = 0; m < MAXE; m++) begin
      case (pat)
        0: begin a = (m / N == m % N) ? 64'd1 : 64'd0; b = 64'(m + 1); end
        1: begin a = 64'd2; b = 64'd3; end
        2: begin a = (m == 0) ? (64'd1 << 32) : 64'd0; b = a; end
        3: begin a = {$urandom, $urandom}; b = {$urandom, $urandom}; end
        default: begin a = 64'(m + 1); b = 64'd1; end
      endcase
      mem[A_W + m] = a;
      mem[B_W + m] = b;
    end
  endtask

  task automatic model(input bit conv);
    logic [63:0] acc;
    if (!conv) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          acc = 0;
          for (int k = 0; k < N; k++) acc = acc + mem[A_W + i * N + k] * mem[B_W + k * N + j];
          exp_c[i * N + j] = acc;
        end
    end else begin
      for (int i = 0; i <= LEN - N; i++) begin
        acc = 0;
        for (int k = 0; k < N; k++) acc = acc + mem[A_W + i + k] * mem[B_W + k];
        exp_c[i] = acc;
      end
    end
  endtask

  task automatic clr_counters(input int mw);
    maxw = mw; wcnt = $urandom_range(0, mw); waits = 0; n_wr = 0; rd_since_wr = 0;
    bad_order = 0; bad_stable = 0; req_seen = 0;
  endtask

  task automatic run(input int id, input vec_t v);
    int cyc, nout;
    bit got, conv;
    conv = v.cv && !v.mm;
    nout = conv ? (LEN - N + 1) : N * N;
    fill(v.pat);
    model(conv);
    clr_counters(v.maxw);
    @(negedge clk);
    smm = v.mm; scv = v.cv;
    @(posedge clk); #1;
    smm = 0; scv = 0;
    cyc = 1; got = 0;
    while (cyc < 3000) begin
      if (npu_done) begin got = 1; break; end
      smm = 0; scv = 0;
      if (v.noise && cyc == 5) smm = 1;
      if (v.noise && cyc == 60) begin smm = 1; scv = 1; end
      @(posedge clk); #1;
      cyc++;
    end
    smm = 0; scv = 0;
    chk($sformatf("v%0d_done_seen", id), 64'(got), 64'd1);
    if (got) begin
      chk($sformatf("v%0d_err", id), 64'(npu_err), 64'(v.exp_err));
      chk($sformatf("v%0d_done_cycle", id), 64'(cyc), 64'(v.exp_cyc + waits));
      if (!v.exp_err) chk($sformatf("v%0d_busy_at_done", id), 64'(npu_busy), 64'd1);
    end
    @(posedge clk); #1;
    chk($sformatf("v%0d_single_done", id), 64'(npu_done), 64'd0);
    chk($sformatf("v%0d_idle_after", id), 64'(npu_busy), 64'd0);
    if (v.exp_err) begin
      chk($sformatf("v%0d_no_req", id), 64'(req_seen), 64'd0);
    end else begin
      chk($sformatf("v%0d_writes", id), 64'(n_wr), 64'(nout));
      chk($sformatf("v%0d_write_order", id), 64'(bad_order), 64'd0);
      chk($sformatf("v%0d_stable", id), 64'(bad_stable), 64'd0);
      for (int e = 0; e < nout; e++)
        chk($sformatf("v%0d_res%0d", id, e), mem[C_W + e], exp_c[e]);
      chk($sformatf("v%0d_no_overrun", id), mem[C_W + nout], 64'hA5A5_0000_0000_0000 | 64'(C_W + nout));
      if (v.chk_ends) begin
        chk($sformatf("v%0d_first", id), mem[C_W], v.exp_first);
        chk($sformatf("v%0d_last", id), mem[C_W + nout - 1], v.exp_last);
      end
    end
  endtask

  vec_t vecs [0:6];
  localparam int MM_CYC = N * N * (3 * N + 1) + 1;
  localparam int CV_CYC = (LEN - N + 1) * (3 * N + 1) + 1;

  initial begin
    int dn;
    vecs[0] = mk(1, 0, 0, 0, 0, 0, MM_CYC, 1, 64'd1, 64'd16);
    vecs[1] = mk(1, 0, 1, 3, 0, 0, MM_CYC, 1, 64'd24, 64'd24);
    vecs[2] = mk(1, 0, 2, 0, 0, 0, MM_CYC, 1, 64'd0, 64'd0);
    vecs[3] = mk(1, 0, 3, 2, 0, 0, MM_CYC, 0, 64'd0, 64'd0);
    vecs[4] = mk(1, 0, 0, 1, 1, 0, MM_CYC, 1, 64'd1, 64'd16);
    vecs[5] = mk(1, 1, 0, 0, 0, 1, 1, 0, 64'd0, 64'd0);
`ifdef NPU_CONV_EN
    vecs[6] = mk(0, 1, 4, 0, 0, 0, CV_CYC, 1, 64'd10, 64'd58);
`else
    vecs[6] = mk(0, 1, 4, 0, 0, 1, 1, 0, 64'd0, 64'd0);
`endif

    #12;
    chk("rst_done", 64'(npu_done), 64'd0);
    chk("rst_busy", 64'(npu_busy), 64'd0);
    chk("rst_err", 64'(npu_err), 64'd0);
    chk("rst_req", 64'(mem_req), 64'd0);
    chk("rst_we", 64'(mem_we), 64'd0);
    chk("rst_addr", mem_addr, 64'd0);
    chk("rst_wdata", mem_wdata, 64'd0);
    @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < 7; i++) run(i, vecs[i]);

    // Reset asserted while the engine is waiting in RD_B.
    fill(0);
    clr_counters(0);
    wcnt = 0;
    @(negedge clk);
    smm = 1;
    @(posedge clk); #1;
    smm = 0;
    @(posedge clk); #1;
    chk("rst_mid_rdb_addr", mem_addr, B_BASE);
    chk("rst_mid_rdb_req", 64'(mem_req), 64'd1);
    rst_n = 0;
    #1;
    chk("rst_mid_req", 64'(mem_req), 64'd0);
    chk("rst_mid_busy", 64'(npu_busy), 64'd0);
    chk("rst_mid_addr", mem_addr, 64'd0);
    dn = 0;
    repeat (4) begin
      @(negedge clk);
      if (npu_done) dn++;
    end
    rst_n = 1;
    repeat (3) begin
      @(negedge clk);
      if (npu_done) dn++;
    end
    chk("rst_mid_no_done", 64'(dn), 64'd0);
    run(7, vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
